// File: rtl/timetag_pkg.sv
// Shared types and default widths for the gated event-count controller.
package timetag_pkg;

    localparam int DEF_CNT_W  = 16;
    localparam int DEF_TIME_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_GATE    = 2'd2,
        ST_REPORT  = 2'd3
    } state_t;

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter shared by the holdoff and gate-window phases.
// 'expired' is high while the count sits at zero, i.e. in the last cycle
// of a phase that was loaded with (length - 1).
module gate_timer
    import timetag_pkg::*;
#(
    parameter int TIME_W = DEF_TIME_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [TIME_W-1:0] load_val,
    input  logic              en,
    output logic              expired
);

    logic [TIME_W-1:0] cnt_q;
    logic [TIME_W-1:0] cnt_d;

    // Next count: load wins over decrement; decrement stops at zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/timetag_gate_ctrl.sv
// Sequences one gated event-count measurement: holdoff, gate window,
// then a valid/ready result with a saturating count and sticky overflow.
module timetag_gate_ctrl
    import timetag_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int TIME_W = DEF_TIME_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [TIME_W-1:0] holdoff_len,
    input  logic [TIME_W-1:0] window_len,
    input  logic              event_in,
    output logic              busy,
    output logic              gate,
    output logic [CNT_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q, state_d;
    logic [TIME_W-1:0]  window_q, window_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;

    logic               tmr_load;
    logic [TIME_W-1:0]  tmr_load_val;
    logic               tmr_en;
    logic               tmr_expired;
    logic [TIME_W-1:0]  win_eff;

    gate_timer #(.TIME_W(TIME_W)) u_gate_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    // A zero window still opens the gate for one cycle.
    assign win_eff = (window_len == '0) ? {{(TIME_W-1){1'b0}}, 1'b1} : window_len;

    // Next-state, timer control and saturating count update.
    always_comb begin
        state_d      = state_q;
        window_d     = window_q;
        count_d      = count_q;
        result_d     = result_q;
        ovf_d        = ovf_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    window_d = win_eff;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                    tmr_load = 1'b1;
                    if (holdoff_len == '0) begin
                        state_d      = ST_GATE;
                        tmr_load_val = win_eff - 1'b1;
                    end else begin
                        state_d      = ST_HOLDOFF;
                        tmr_load_val = holdoff_len - 1'b1;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (tmr_expired) begin
                    state_d      = ST_GATE;
                    tmr_load     = 1'b1;
                    tmr_load_val = window_q - 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_GATE: begin
                if (event_in) begin
                    if (count_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                if (tmr_expired) begin
                    state_d  = ST_REPORT;
                    result_d = count_d;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_REPORT: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort drops the measurement and any pending result publication.
        if (abort && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    // State and datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            window_q <= '0;
            count_q  <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            window_q <= window_d;
            count_q  <= count_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign gate         = (state_q == ST_GATE);
    assign result_valid = (state_q == ST_REPORT);
    assign result       = result_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_timetag_gate_ctrl.sv
// Directed bench for timetag_gate_ctrl, built with a 4-bit count so that
// saturation is reachable in a short gate window.
module tb_timetag_gate_ctrl;

    localparam int CNT_W  = 4;
    localparam int TIME_W = 8;

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic [TIME_W-1:0] holdoff_len;
    logic [TIME_W-1:0] window_len;
    logic              event_in;
    logic              busy;
    logic              gate;
    logic [CNT_W-1:0]  result;
    logic              result_valid;
    logic              result_ready;
    logic              overflow;

    int checks = 0;
    int errors = 0;
    int gate_cycles;

    timetag_gate_ctrl #(.CNT_W(CNT_W), .TIME_W(TIME_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .holdoff_len  (holdoff_len),
        .window_len   (window_len),
        .event_in     (event_in),
        .busy         (busy),
        .gate         (gate),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overflow     (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  32'(busy),         32'd0);
        check({tag, "_gate"},  32'(gate),         32'd0);
        check({tag, "_valid"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        holdoff_len  = '0;
        window_len   = '0;
        event_in     = 1'b0;
        result_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check_idle("rst");
        check("rst_result",   32'(result),   32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        tick();
        check_idle("rst_release");

        // 1: holdoff 3, window 5, constant events, ready held high
        holdoff_len  = 8'd3;
        window_len   = 8'd5;
        event_in     = 1'b1;
        result_ready = 1'b1;
        start        = 1'b1;
        tick();
        start       = 1'b0;
        holdoff_len = 8'd0;   // config changes after acceptance have no effect
        window_len  = 8'd1;
        check("t1_busy0", 32'(busy), 32'd1);
        check("t1_gate0", 32'(gate), 32'd0);
        gate_cycles = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (gate) gate_cycles++;
            check($sformatf("t1_gate%0d", i),  32'(gate),         (i >= 3 && i <= 7) ? 32'd1 : 32'd0);
            check($sformatf("t1_valid%0d", i), 32'(result_valid), (i == 8) ? 32'd1 : 32'd0);
        end
        check("t1_gate_cycles", 32'(gate_cycles), 32'd5);
        check("t1_result",      32'(result),      32'd5);
        check("t1_overflow",    32'(overflow),    32'd0);
        tick();
        check_idle("t1_done");

        // 2: zero holdoff, zero window -> single gate cycle at acceptance
        holdoff_len = 8'd0;
        window_len  = 8'd0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        check("t2_gate_at_accept", 32'(gate), 32'd1);
        check("t2_busy",           32'(busy), 32'd1);
        tick();
        check("t2_gate_off", 32'(gate),         32'd0);
        check("t2_valid",    32'(result_valid), 32'd1);
        check("t2_result",   32'(result),       32'd1);
        tick();
        check_idle("t2_done");

        // 3: 20 events into a 4-bit counter saturate at 15 with overflow
        window_len = 8'd20;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("t3_valid",    32'(result_valid), 32'd1);
        check("t3_result",   32'(result),       32'd15);
        check("t3_overflow", 32'(overflow),     32'd1);
        tick();
        check_idle("t3_done");
        // back-to-back start: overflow cleared on acceptance
        window_len = 8'd2;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check("t3b_ovf_clear", 32'(overflow), 32'd0);
        tick();
        tick();
        check("t3b_valid",    32'(result_valid), 32'd1);
        check("t3b_result",   32'(result),       32'd2);
        check("t3b_overflow", 32'(overflow),     32'd0);
        tick();
        check_idle("t3b_done");

        // 4: events outside the gate ignored; result held while ready low
        result_ready = 1'b0;
        holdoff_len  = 8'd2;
        window_len   = 8'd4;
        event_in     = 1'b1;
        start        = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t4_gate_open", 32'(gate), 32'd1);
        event_in = 1'b1; tick();
        event_in = 1'b0; tick();
        event_in = 1'b1; tick();
        event_in = 1'b1; tick();
        check("t4_valid", 32'(result_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            event_in = (i % 2 == 0);
            tick();
            check($sformatf("t4_hold_result%0d", i), 32'(result),       32'd3);
            check($sformatf("t4_hold_valid%0d", i),  32'(result_valid), 32'd1);
            check($sformatf("t4_hold_busy%0d", i),   32'(busy),         32'd1);
        end
        result_ready = 1'b1;
        tick();
        check_idle("t4_done");
        check("t4_result_kept", 32'(result), 32'd3);

        // 5a: abort in the 2nd gate cycle
        holdoff_len = 8'd0;
        window_len  = 8'd5;
        event_in    = 1'b1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t5_gate2", 32'(gate), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("t5_abort");
        check("t5_result_kept", 32'(result), 32'd3);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("t5_no_valid%0d", i), 32'(result_valid), 32'd0);
        end

        // 5b: abort together with start in IDLE blocks the start
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_idle("t5_abort_start");

        // 5c: start during GATE is ignored
        window_len = 8'd3;
        start      = 1'b1;
        tick();
        window_len = 8'd10;
        tick();
        start = 1'b0;
        tick();
        check("t5c_gate3", 32'(gate), 32'd1);
        tick();
        check("t5c_valid",  32'(result_valid), 32'd1);
        check("t5c_result", 32'(result),       32'd3);
        tick();
        check_idle("t5c_done");

        // 6: reset mid-gate, then a fresh measurement
        holdoff_len = 8'd1;
        window_len  = 8'd6;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t6_gate", 32'(gate), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_idle("t6_reset");
        check("t6_result",   32'(result),   32'd0);
        check("t6_overflow", 32'(overflow), 32'd0);
        holdoff_len = 8'd0;
        window_len  = 8'd2;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t6_fresh_valid",  32'(result_valid), 32'd1);
        check("t6_fresh_result", 32'(result),       32'd2);
        tick();
        check_idle("t6_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timetag_gate_ctrl.md
Name: timetag_gate_ctrl

Overview:
Sequences one gated event-count measurement for the time-tagging front end.
- On `start`, waits a programmable holdoff, then opens a counting gate for a programmable window.
- Counts `event_in` pulses while the gate is open.
- Presents the saturated count on a valid/ready result interface.
- Sits between the host/configuration logic and the per-channel event counting datapath; owns the gate timing and the counter clear/enable sequencing.

Parameters:
- CNT_W, 16, width of event count / result
- TIME_W, 24, width of holdoff and window lengths (clock cycles)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0)
- start  in  1  single-cycle request to begin a measurement; honoured only in IDLE
- abort  in  1  cancels any measurement in progress
- holdoff_len  in  TIME_W  cycles between start acceptance and gate open; sampled on accepted start
- window_len  in  TIME_W  gate-open duration in cycles; sampled on accepted start; 0 treated as 1
- event_in  in  1  event strobe, one count per high cycle while gate open
- busy  out  1  high in any state other than IDLE
- gate  out  1  high exactly during GATE state
- result  out  CNT_W  final event count; stable while result_valid
- result_valid  out  1  result available (REPORT state)
- result_ready  in  1  consumer accepts result when high with result_valid
- overflow  out  1  count saturated during this measurement; valid alongside result

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; busy=0, gate=0, result_valid=0, result=0, overflow=0; internal timer and count cleared. Reset mid-measurement discards everything.
- States: IDLE, HOLDOFF, GATE, REPORT. All outputs are registered and decoded from state/registers; no combinational path from inputs to outputs.
- Start acceptance:
  - In IDLE with start=1 and abort=0 at edge N, the controller latches holdoff_len/window_len and clears count and overflow.
  - From edge N it is in HOLDOFF, or in GATE if holdoff_len==0.
  - start is ignored outside IDLE.
- HOLDOFF: lasts exactly holdoff_len cycles, then GATE.
- GATE:
  - Lasts exactly max(window_len,1) cycles; gate=1 in every one of those cycles.
  - Each cycle in GATE with event_in=1 increments count by 1.
  - Events outside GATE are never counted.
- Saturation: count stops at 2^CNT_W-1. An event arriving at that value sets overflow=1 (sticky until next accepted start or reset). No wrap-around.
- REPORT:
  - Entered on the edge after the last GATE cycle; result=count and result_valid=1.
  - result/overflow held stable until handshake.
  - result_valid&&result_ready at an edge → IDLE on that edge; result_valid drops the next cycle.
  - result_ready may be high in advance, giving a minimum REPORT duration of 1 cycle.
  - Total start-to-valid latency: holdoff_len + max(window_len,1) cycles after the acceptance edge.
- Abort:
  - abort=1 in any non-IDLE state → IDLE at that edge; no result produced (result_valid forced 0, result retains last value).
  - abort in IDLE is a no-op and blocks a simultaneous start.
  - abort overrides a simultaneous valid/ready handshake; the result counts as dropped.
- Timer: a single TIME_W down-counter, reused for holdoff and window, loaded on state entry.
- Config inputs may change freely after acceptance without effect.
- back-to-back: a start in the cycle after the handshake (state IDLE) is accepted normally.

Decomposition:
- Shared package `timetag_pkg`: state enum (IDLE/HOLDOFF/GATE/REPORT), default CNT_W/TIME_W constants.
- One natural sub-module: `gate_timer` (loadable TIME_W down-counter with load, enable, and `expired` flag), instantiated once.
- Saturating event counter stays inline.

Test Plan:
- holdoff_len=3, window_len=5, event_in=1 constantly, result_ready=1 → gate high for exactly 5 cycles starting 3 cycles after acceptance; result=5, overflow=0; result_valid for 1 cycle.
- holdoff_len=0, window_len=0, event_in=1 → gate 1 cycle starting at the acceptance edge; result=1.
- CNT_W=4, window_len=20, event_in=1 → result=15, overflow=1; next start with window_len=2 → result=2, overflow=0.
- window_len=4, result_ready=0 for 10 cycles, then 1; event_in toggled/pulsed during HOLDOFF and REPORT → result stable, busy=1 throughout; only in-gate events counted; IDLE the edge after ready.
- Abort in the 2nd GATE cycle → busy=0 next cycle, no result_valid. Separately, abort+start together in IDLE → stays IDLE. start during GATE → ignored.
- reset=0 asserted mid-GATE → all outputs 0 on the next cycle; a fresh measurement afterwards gives the correct count.
